// File: rtl/bp_me_mem_cmd_arbiter_pkg.sv
// bp_me_mem_cmd_arbiter_pkg
// Shared constants and helpers for the memory command arbiter slice.
// Messages are opaque vectors. Only the default message width and the id
// width helper live here.
package bp_me_mem_cmd_arbiter_pkg;

    // Default opaque memory message width, used when no width is supplied.
    localparam int cce_mem_msg_width_lp = 32;

    // Returns the clog2 of n, but never less than 1, so that a 1-entry
    // structure still gets a usable index.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_me_mem_cmd_arbiter_if.sv
// bp_me_mem_cmd_arbiter_if
// Bundles the command and response buses that sit between the requesters,
// the arbiter and the memory endpoint.
//   slave  : arbiter view (consumes commands and responses, drives grants/routing)
//   master : environment view (requesters plus memory)
// Requester i owns mem_cmd_i[i*msg_width_p +: msg_width_p].
interface bp_me_mem_cmd_arbiter_if
    import bp_me_mem_cmd_arbiter_pkg::*;
#(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = cce_mem_msg_width_lp
);
    logic [num_req_p*msg_width_p-1:0] mem_cmd_i;
    logic [num_req_p-1:0]             mem_cmd_v_i;
    logic [num_req_p-1:0]             mem_cmd_yumi_o;
    logic [msg_width_p-1:0]           mem_cmd_o;
    logic                             mem_cmd_v_o;
    logic                             mem_cmd_ready_i;
    logic [msg_width_p-1:0]           mem_resp_i;
    logic                             mem_resp_v_i;
    logic                             mem_resp_yumi_o;
    logic [msg_width_p-1:0]           mem_resp_o;
    logic [num_req_p-1:0]             mem_resp_v_o;
    logic [num_req_p-1:0]             mem_resp_yumi_i;

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
               mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
        output mem_cmd_yumi_o, mem_cmd_o, mem_cmd_v_o,
               mem_resp_yumi_o, mem_resp_o, mem_resp_v_o
    );

    modport master (
        output mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
               mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
        input  mem_cmd_yumi_o, mem_cmd_o, mem_cmd_v_o,
               mem_resp_yumi_o, mem_resp_o, mem_resp_v_o
    );
endinterface

// File: rtl/bp_me_mem_cmd_arbiter_chk.sv
// bp_me_mem_cmd_arbiter_chk
// Simulation-only protocol checks for the arbiter. It has no outputs.
//   mem_resp_v_i : memory response valid
//   owner_v_i    : owner FIFO holds at least one id
//   load_i       : output slot loads this cycle
//   win_id_i     : arbiter winner id
//   rr_i         : last-winner register
//   yumi_i       : command consume vector
//   cmd_v_i      : command valid vector
module bp_me_mem_cmd_arbiter_chk #(
    parameter int num_req_p     = 2,
    parameter int lg_num_req_lp = 1
)(
    input logic                     clk_i,
    input logic                     reset_n_i,
    input logic                     mem_resp_v_i,
    input logic                     owner_v_i,
    input logic                     load_i,
    input logic [lg_num_req_lp-1:0] win_id_i,
    input logic [lg_num_req_lp-1:0] rr_i,
    input logic [num_req_p-1:0]     yumi_i,
    input logic [num_req_p-1:0]     cmd_v_i
);

    // A response with no recorded owner means memory answered a command we never issued.
    resp_has_owner_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_v_i |-> owner_v_i);

    // At most one requester is consumed per cycle.
    yumi_onehot_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(yumi_i));

    // Never consume a requester that is not offering a command.
    yumi_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (yumi_i & ~cmd_v_i) == '0);

    // The priority pointer follows every load.
    rr_follows_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        load_i |=> (rr_i == $past(win_id_i)));

endmodule

// File: rtl/bp_me_mem_cmd_arbiter_rr.sv
// bp_me_rr_arbiter
// N-way round-robin arbiter. Priority starts one past the last winner and
// wraps modulo num_req_p.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   req_i            : request vector
//   adv_i            : commit the current winner as the new last winner
//   grant_o          : one-hot grant (zero when no request is present)
//   id_o             : encoded winner id
//   rr_o             : last-winner register (resets to num_req_p-1)
module bp_me_rr_arbiter
    import bp_me_mem_cmd_arbiter_pkg::*;
#(
    parameter  int num_req_p     = 2,
    localparam int lg_num_req_lp = safe_clog2(num_req_p)
)(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [num_req_p-1:0]     req_i,
    input  logic                     adv_i,
    output logic [num_req_p-1:0]     grant_o,
    output logic [lg_num_req_lp-1:0] id_o,
    output logic [lg_num_req_lp-1:0] rr_o
);

    logic [lg_num_req_lp-1:0] rr_r;
    logic [num_req_p-1:0]     grant_s;
    logic [lg_num_req_lp-1:0] id_s;
    logic                     found_s;

    // Scan rr_r+1 .. rr_r+num_req_p (mod num_req_p); first requester seen wins.
    always_comb begin
        int   idx_v;
        logic hit_v;
        grant_s = '0;
        id_s    = '0;
        found_s = 1'b0;
        idx_v   = 0;
        hit_v   = 1'b0;
        for (int k = 1; k <= num_req_p; k++) begin
            idx_v   = ((int'(rr_r) + k) >= num_req_p) ? (int'(rr_r) + k - num_req_p)
                                                      : (int'(rr_r) + k);
            hit_v   = req_i[idx_v] & ~found_s;
            grant_s[idx_v] = grant_s[idx_v] | hit_v;
            id_s    = hit_v ? lg_num_req_lp'(idx_v) : id_s;
            found_s = found_s | hit_v;
        end
    end

    // Last-winner register; reset value gives requester 0 first priority.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r <= lg_num_req_lp'(num_req_p - 1);
        end else if (adv_i) begin
            rr_r <= id_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    assign grant_o = grant_s;
    assign id_o    = id_s;
    assign rr_o    = rr_r;

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter
// Shares one memory port among num_req_p requesters. A round-robin winner is
// loaded into a one-entry registered command slot. Each loaded command pushes
// its requester id onto an in-order owner FIFO. The in-order memory responses
// are routed combinationally back to the id at the FIFO head.
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   mem_if    : command/response bus (slave view), see bp_me_mem_cmd_arbiter_if
module bp_me_mem_cmd_arbiter
    import bp_me_mem_cmd_arbiter_pkg::*;
#(
    parameter  int num_req_p         = 2,
    parameter  int msg_width_p       = cce_mem_msg_width_lp,
    parameter  int max_outstanding_p = 4,
    localparam int lg_num_req_lp     = safe_clog2(num_req_p)
)(
    input logic clk_i,
    input logic reset_n_i,
    bp_me_mem_cmd_arbiter_if.slave mem_if
);

    localparam int ptr_w_lp = safe_clog2(max_outstanding_p);
    localparam int cnt_w_lp = safe_clog2(max_outstanding_p + 1);

    logic [num_req_p-1:0]     grant_s;
    logic [lg_num_req_lp-1:0] win_id_s;
    logic [lg_num_req_lp-1:0] rr_s;
    logic [msg_width_p-1:0]   cmd_sel_s;
    logic                     load_s;
    logic                     owner_v_s;
    logic                     owner_full_s;
    logic                     pop_s;
    logic [lg_num_req_lp-1:0] head_s;

    logic                     cmd_v_r;
    logic [msg_width_p-1:0]   cmd_r;
    logic [lg_num_req_lp-1:0] owner_mem_r [max_outstanding_p];
    logic [ptr_w_lp-1:0]      wr_ptr_r;
    logic [ptr_w_lp-1:0]      rd_ptr_r;
    logic [cnt_w_lp-1:0]      count_r;

    bp_me_rr_arbiter #(.num_req_p(num_req_p)) u_rr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req_i     (mem_if.mem_cmd_v_i),
        .adv_i     (load_s),
        .grant_o   (grant_s),
        .id_o      (win_id_s),
        .rr_o      (rr_s)
    );

    // The full check uses the registered count only, so a same-cycle pop does not unblock a load.
    // reset_n_i gating keeps every combinational output quiet while reset is held.
    always_comb begin
        owner_v_s    = (count_r != cnt_w_lp'(0));
        owner_full_s = (count_r == cnt_w_lp'(max_outstanding_p));
        load_s       = reset_n_i & (|mem_if.mem_cmd_v_i)
                     & (~cmd_v_r | mem_if.mem_cmd_ready_i) & ~owner_full_s;
        head_s       = owner_mem_r[rd_ptr_r];
        pop_s        = reset_n_i & owner_v_s & mem_if.mem_resp_yumi_i[head_s];
    end

    // Select the winning requester's message with a one-hot AND-OR mux.
    always_comb begin
        cmd_sel_s = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cmd_sel_s = cmd_sel_s
                      | (grant_s[i] ? mem_if.mem_cmd_i[i*msg_width_p +: msg_width_p]
                                    : {msg_width_p{1'b0}});
        end
    end

    // Output slot: load a new winner, drain on ready, otherwise hold.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_v_r <= 1'b0;
            cmd_r   <= '0;
        end else if (load_s) begin
            cmd_v_r <= 1'b1;
            cmd_r   <= cmd_sel_s;
        end else if (mem_if.mem_cmd_ready_i) begin
            cmd_v_r <= 1'b0;
        end else begin
            cmd_v_r <= cmd_v_r;
        end
    end

    // Owner FIFO: a circular buffer of requester ids plus an occupancy count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < max_outstanding_p; i++) begin
                owner_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (load_s) begin
                owner_mem_r[wr_ptr_r] <= win_id_s;
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_outstanding_p - 1))
                          ? ptr_w_lp'(0) : wr_ptr_r + ptr_w_lp'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_outstanding_p - 1))
                          ? ptr_w_lp'(0) : rd_ptr_r + ptr_w_lp'(1);
            end
            case ({load_s, pop_s})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign mem_if.mem_cmd_yumi_o  = load_s ? grant_s : {num_req_p{1'b0}};
    assign mem_if.mem_cmd_o       = cmd_r;
    assign mem_if.mem_cmd_v_o     = cmd_v_r;
    assign mem_if.mem_resp_o      = mem_if.mem_resp_i;
    assign mem_if.mem_resp_v_o    = (reset_n_i & owner_v_s & mem_if.mem_resp_v_i)
                                  ? (num_req_p'(1) << head_s) : {num_req_p{1'b0}};
    assign mem_if.mem_resp_yumi_o = pop_s;

    bp_me_mem_cmd_arbiter_chk #(
        .num_req_p     (num_req_p),
        .lg_num_req_lp (lg_num_req_lp)
    ) u_chk (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .mem_resp_v_i (mem_if.mem_resp_v_i),
        .owner_v_i    (owner_v_s),
        .load_i       (load_s),
        .win_id_i     (win_id_s),
        .rr_i         (rr_s),
        .yumi_i       (mem_if.mem_cmd_yumi_o),
        .cmd_v_i      (mem_if.mem_cmd_v_i)
    );

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Self-checking bench for bp_me_mem_cmd_arbiter. The reference model tracks
// the slot, the count of outstanding commands and a queue standing in for
// memory. Each command carries its issuer id in its top 4 bits, so the
// response owner is read straight off the response data.
module tb_bp_me_mem_cmd_arbiter;
    import bp_me_mem_cmd_arbiter_pkg::*;

    localparam int NR   = 2;
    localparam int W    = 32;
    localparam int MAXO = 4;

    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    bp_me_mem_cmd_arbiter_if #(.num_req_p(NR), .msg_width_p(W)) mem_if ();

    bp_me_mem_cmd_arbiter #(
        .num_req_p(NR), .msg_width_p(W), .max_outstanding_p(MAXO)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .mem_if(mem_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int             m_last;
    bit             m_slot_v;
    logic [W-1:0]   m_slot_d;
    int             m_out;
    logic [W-1:0]   mem_q [$];
    logic [W-1:0]   req_d [NR];
    // Expectations for the cycle currently being driven
    logic           exp_load;
    int             exp_w;
    logic [NR-1:0]  exp_yumi;
    logic [NR-1:0]  exp_resp_v;
    logic           exp_resp_yumi;

    function automatic logic [W-1:0] new_cmd(input int i);
        return {4'(i), 28'($urandom)};
    endfunction

    function automatic logic [W-1:0] resp_of(input logic [W-1:0] c);
        return {c[W-1:W-4], ~c[W-5:0]};
    endfunction

    task automatic model_reset();
        m_last   = NR - 1;
        m_slot_v = 1'b0;
        m_slot_d = '0;
        m_out    = 0;
        mem_q.delete();
    endtask

    task automatic zero_inputs();
        mem_if.mem_cmd_i       = '0;
        mem_if.mem_cmd_v_i     = '0;
        mem_if.mem_cmd_ready_i = 1'b0;
        mem_if.mem_resp_i      = '0;
        mem_if.mem_resp_v_i    = 1'b0;
        mem_if.mem_resp_yumi_i = '0;
    endtask

    // Drive one cycle of stimulus (percent probabilities) and compute expectations.
    task automatic drive(input int pv, input int pready, input int presp,
                         input int pyumi, input logic [NR-1:0] vmask);
        logic [NR-1:0] v;
        logic [NR-1:0] oh;
        for (int i = 0; i < NR; i++) begin
            v[i] = vmask[i] && ($urandom_range(99) < pv);
            mem_if.mem_cmd_i[i*W +: W] = req_d[i];
        end
        mem_if.mem_cmd_v_i     = v;
        mem_if.mem_cmd_ready_i = ($urandom_range(99) < pready);
        mem_if.mem_resp_v_i    = (mem_q.size() > 0) && ($urandom_range(99) < presp);
        if (mem_if.mem_resp_v_i) begin
            oh = NR'(1) << int'(mem_q[0][W-1:W-4]);
            mem_if.mem_resp_i      = resp_of(mem_q[0]);
            mem_if.mem_resp_yumi_i = (NR'($urandom) & ~oh)
                                   | (($urandom_range(99) < pyumi) ? oh : '0);
        end else begin
            oh = '0;
            mem_if.mem_resp_i      = $urandom;
            mem_if.mem_resp_yumi_i = '0;
        end
        exp_load = (|v) && (!m_slot_v || mem_if.mem_cmd_ready_i) && (m_out < MAXO);
        exp_w = -1;
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (m_last + k) % NR;
            if (exp_w < 0 && v[j]) exp_w = j;
        end
        exp_yumi      = exp_load ? (NR'(1) << exp_w) : '0;
        exp_resp_v    = mem_if.mem_resp_v_i ? oh : '0;
        exp_resp_yumi = |(mem_if.mem_resp_yumi_i & oh);
    endtask

    // Advance the model across the clock edge just taken.
    task automatic commit();
        if (exp_resp_yumi) begin
            mem_q.delete(0);
            m_out--;
        end
        if (m_slot_v && mem_if.mem_cmd_ready_i) mem_q.push_back(m_slot_d);
        if (exp_load) begin
            m_slot_v = 1'b1;
            m_slot_d = req_d[exp_w];
            m_last   = exp_w;
            m_out++;
            req_d[exp_w] = new_cmd(exp_w);
        end else if (mem_if.mem_cmd_ready_i) begin
            m_slot_v = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        commit();
        #1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((m_out > 0 || m_slot_v) && c < 60) begin
            drive(0, 100, 100, 100, 2'b00);
            tick();
            c++;
        end
        zero_inputs();
        if (m_out > 0 || m_slot_v) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout outstanding=%0d required=0", m_out);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        mem_if.mem_cmd_v_i     = 2'b11;
        mem_if.mem_cmd_ready_i = 1'b1;
        mem_if.mem_resp_v_i    = 1'b1;
        mem_if.mem_resp_yumi_i = 2'b11;
        @(posedge clk_i); #2;
        n_vec++; if (mem_if.mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL rst_cmd_v got=%b exp=0", mem_if.mem_cmd_v_o); end
        n_vec++; if (mem_if.mem_cmd_o !== '0) begin n_err++; $display("FAIL rst_cmd got=%h exp=0", mem_if.mem_cmd_o); end
        n_vec++; if (mem_if.mem_cmd_yumi_o !== 2'b00) begin n_err++; $display("FAIL rst_yumi got=%b exp=00", mem_if.mem_cmd_yumi_o); end
        n_vec++; if (mem_if.mem_resp_v_o !== 2'b00) begin n_err++; $display("FAIL rst_resp_v got=%b exp=00", mem_if.mem_resp_v_o); end
        n_vec++; if (mem_if.mem_resp_yumi_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_yumi got=%b exp=0", mem_if.mem_resp_yumi_o); end
        zero_inputs();
        model_reset();
        @(negedge clk_i); reset_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_single_requester();
        for (int c = 0; c < 10; c++) begin
            if (c < 3) drive(100, 100, 0, 0, 2'b01);
            else       drive(0, 100, 100, 100, 2'b00);
            @(negedge clk_i);
            n_vec++;
            if ({mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o, mem_if.mem_resp_v_o, mem_if.mem_resp_yumi_o, mem_if.mem_resp_o}
                !== {exp_yumi, m_slot_v, m_slot_d, exp_resp_v, exp_resp_yumi, mem_if.mem_resp_i}) begin
                n_err++; $display("FAIL single c=%0d yumi=%b/%b cmd_v=%b/%b cmd=%h/%h resp_v=%b/%b ry=%b/%b", c,
                    mem_if.mem_cmd_yumi_o, exp_yumi, mem_if.mem_cmd_v_o, m_slot_v, mem_if.mem_cmd_o, m_slot_d,
                    mem_if.mem_resp_v_o, exp_resp_v, mem_if.mem_resp_yumi_o, exp_resp_yumi);
            end
            if (c < 3) begin
                n_vec++; if (mem_if.mem_cmd_yumi_o !== 2'b01) begin n_err++; $display("FAIL single_yumi c=%0d got=%b exp=01", c, mem_if.mem_cmd_yumi_o); end
            end
            if (mem_if.mem_resp_v_i) begin
                n_vec++; if (mem_if.mem_resp_v_o !== 2'b01) begin n_err++; $display("FAIL single_route got=%b exp=01", mem_if.mem_resp_v_o); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_fairness();
        int prev_g;
        int prev_r;
        prev_g = -1; prev_r = -1;
        for (int c = 0; c < 24; c++) begin
            drive(100, 100, 100, 100, 2'b11);
            @(negedge clk_i);
            n_vec++;
            if ({mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o, mem_if.mem_resp_v_o, mem_if.mem_resp_yumi_o, mem_if.mem_resp_o}
                !== {exp_yumi, m_slot_v, m_slot_d, exp_resp_v, exp_resp_yumi, mem_if.mem_resp_i}) begin
                n_err++; $display("FAIL fair c=%0d yumi=%b/%b cmd=%h/%h resp_v=%b/%b", c,
                    mem_if.mem_cmd_yumi_o, exp_yumi, mem_if.mem_cmd_o, m_slot_d, mem_if.mem_resp_v_o, exp_resp_v);
            end
            if (exp_load && prev_g >= 0) begin
                n_vec++;
                if (mem_if.mem_cmd_yumi_o !== ((prev_g == 0) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL fair_alt c=%0d got=%b prev_winner=%0d", c, mem_if.mem_cmd_yumi_o, prev_g);
                end
            end
            if (exp_resp_yumi && prev_r >= 0) begin
                n_vec++;
                if (mem_if.mem_resp_v_o !== ((prev_r == 0) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL fair_resp_alt c=%0d got=%b prev_owner=%0d", c, mem_if.mem_resp_v_o, prev_r);
                end
            end
            if (exp_load) prev_g = exp_w;
            if (exp_resp_yumi) prev_r = int'(mem_if.mem_resp_i[W-1:W-4]);
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        held = req_d[0];
        drive(100, 100, 0, 0, 2'b01);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(100, 0, 0, 0, 2'b11);
            @(negedge clk_i);
            n_vec++;
            if ({mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o} !== {exp_yumi, m_slot_v, m_slot_d}) begin
                n_err++; $display("FAIL bp c=%0d yumi=%b/%b cmd_v=%b/%b cmd=%h/%h", c,
                    mem_if.mem_cmd_yumi_o, exp_yumi, mem_if.mem_cmd_v_o, m_slot_v, mem_if.mem_cmd_o, m_slot_d);
            end
            n_vec++;
            if ({mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o} !== {2'b00, 1'b1, held}) begin
                n_err++; $display("FAIL bp_hold c=%0d yumi=%b cmd_v=%b cmd=%h exp cmd=%h", c,
                    mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o, held);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_fifo_full();
        for (int c = 0; c < 8; c++) begin
            if (c == 6)      drive(100, 100, 100, 100, 2'b11);
            else if (c == 7) drive(100, 100, 0, 0, 2'b11);
            else             drive(100, 100, 0, 0, 2'b11);
            @(negedge clk_i);
            n_vec++;
            if ({mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o, mem_if.mem_resp_v_o, mem_if.mem_resp_yumi_o}
                !== {exp_yumi, m_slot_v, m_slot_d, exp_resp_v, exp_resp_yumi}) begin
                n_err++; $display("FAIL full c=%0d yumi=%b/%b cmd_v=%b/%b resp_v=%b/%b ry=%b/%b", c,
                    mem_if.mem_cmd_yumi_o, exp_yumi, mem_if.mem_cmd_v_o, m_slot_v,
                    mem_if.mem_resp_v_o, exp_resp_v, mem_if.mem_resp_yumi_o, exp_resp_yumi);
            end
            n_vec++;
            if (c >= 4 && c <= 6) begin
                if (mem_if.mem_cmd_yumi_o !== 2'b00) begin n_err++; $display("FAIL full_block c=%0d got=%b exp=00", c, mem_if.mem_cmd_yumi_o); end
            end else if (c == 7) begin
                if (mem_if.mem_cmd_yumi_o === 2'b00) begin n_err++; $display("FAIL full_reload got=%b exp=nonzero", mem_if.mem_cmd_yumi_o); end
            end else begin
                if (mem_if.mem_cmd_yumi_o === 2'b00) begin n_err++; $display("FAIL full_fill c=%0d got=%b exp=nonzero", c, mem_if.mem_cmd_yumi_o); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_consumer_stall();
        drive(100, 100, 0, 0, 2'b10);
        tick();
        drive(0, 100, 0, 0, 2'b00);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(0, 100, 100, (c == 3) ? 100 : 0, 2'b00);
            @(negedge clk_i);
            n_vec++;
            if ({mem_if.mem_resp_v_o, mem_if.mem_resp_yumi_o} !== {2'b10, (c == 3)}) begin
                n_err++; $display("FAIL stall c=%0d resp_v=%b ry=%b exp resp_v=10 ry=%0d", c,
                    mem_if.mem_resp_v_o, mem_if.mem_resp_yumi_o, (c == 3));
            end
            tick();
        end
        n_vec++;
        if (m_out != 0) begin n_err++; $display("FAIL stall_pop outstanding=%0d exp=0", m_out); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(100, 100, 0, 0, 2'b11); tick();
        drive(100, 100, 0, 0, 2'b11); tick();
        zero_inputs();
        reset_n_i = 1'b0;
        #1;
        n_vec++; if (mem_if.mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL midrst_cmd_v got=%b exp=0", mem_if.mem_cmd_v_o); end
        n_vec++; if (mem_if.mem_resp_yumi_o !== 1'b0) begin n_err++; $display("FAIL midrst_ry got=%b exp=0", mem_if.mem_resp_yumi_o); end
        model_reset();
        @(negedge clk_i); reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        drive(100, 100, 0, 0, 2'b11);
        @(negedge clk_i);
        n_vec++; if (mem_if.mem_cmd_yumi_o !== 2'b01) begin n_err++; $display("FAIL midrst_first got=%b exp=01", mem_if.mem_cmd_yumi_o); end
        tick();
        drain();
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 400; c++) begin
            drive(60, 70, 50, 70, 2'b11);
            @(negedge clk_i);
            n_vec++;
            if ({mem_if.mem_cmd_yumi_o, mem_if.mem_cmd_v_o, mem_if.mem_cmd_o, mem_if.mem_resp_v_o, mem_if.mem_resp_yumi_o, mem_if.mem_resp_o}
                !== {exp_yumi, m_slot_v, m_slot_d, exp_resp_v, exp_resp_yumi, mem_if.mem_resp_i}) begin
                n_err++; $display("FAIL rand c=%0d yumi=%b/%b cmd_v=%b/%b cmd=%h/%h resp_v=%b/%b ry=%b/%b", c,
                    mem_if.mem_cmd_yumi_o, exp_yumi, mem_if.mem_cmd_v_o, m_slot_v, mem_if.mem_cmd_o, m_slot_d,
                    mem_if.mem_resp_v_o, exp_resp_v, mem_if.mem_resp_yumi_o, exp_resp_yumi);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) req_d[i] = new_cmd(i);
        zero_inputs();
        model_reset();
        test_reset();
        test_single_requester();
        test_fairness();
        test_backpressure();
        test_fifo_full();
        test_consumer_stall();
        test_reset_mid();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
# bp_me_mem_cmd_arbiter

Shares one memory port (bp_mem or an equivalent cache/DRAM endpoint) among `num_req_p` CCE-side requesters, such as multiple CCEs or a CCE plus a config/IO master. Round-robin arbitration selects commands into a one-entry registered output slot. An in-order tag FIFO records which requester owns each outstanding command, so that in-order memory responses are routed back to the correct requester.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters (≥2).
- `msg_width_p`, `cce_mem_msg_width_lp`: bits per memory message.
- `max_outstanding_p`, 4: depth of the owner FIFO. It caps commands issued but not yet response-delivered.
- `lg_num_req_lp`, `BSG_SAFE_CLOG2(num_req_p)`: localparam, requester id width.

Ports:
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `mem_cmd_i`, in, `num_req_p*msg_width_p`: per-requester command. Requester i occupies slice [i*msg_width_p +: msg_width_p].
- `mem_cmd_v_i`, in, `num_req_p`: per-requester command valid.
- `mem_cmd_yumi_o`, out, `num_req_p`: one-hot command consume.
- `mem_cmd_o`, out, `msg_width_p`: registered command to memory.
- `mem_cmd_v_o`, out, 1: registered command valid.
- `mem_cmd_ready_i`, in, 1: memory accepts `mem_cmd_o`.
- `mem_resp_i`, in, `msg_width_p`: memory response. Responses are in command order.
- `mem_resp_v_i`, in, 1: response valid.
- `mem_resp_yumi_o`, out, 1: response consumed.
- `mem_resp_o`, out, `msg_width_p`: response broadcast to all requesters. Equals `mem_resp_i`.
- `mem_resp_v_o`, out, `num_req_p`: one-hot response valid to the owning requester.
- `mem_resp_yumi_i`, in, `num_req_p`: per-requester response consume.

## Operation
Output slot:
- `load = any(mem_cmd_v_i) & (~mem_cmd_v_o | mem_cmd_ready_i) & ~owner_full`.
- On `load`:
  - Winner w's message is registered into `mem_cmd_o`.
  - `mem_cmd_yumi_o[w]=1` in the same cycle.
  - w is pushed onto the owner FIFO.
  - `rr_q` ← w.
- On `mem_cmd_v_o & mem_cmd_ready_i & ~load`: `mem_cmd_v_o` clears.

Arbitration:
- Priority order is `rr_q+1, rr_q+2, …` modulo `num_req_p`, wrapping at `num_req_p-1` → 0.
- Exactly one yumi may be asserted per cycle.
- Yumi is never asserted to a requester with `mem_cmd_v_i=0`.

Owner FIFO and response routing:
- Holds up to `max_outstanding_p` ids.
- `owner_full` is evaluated on the registered count. It ignores a same-cycle pop, which is conservative: a full FIFO blocks `load` even when a response retires in that cycle.
- Routing: `mem_resp_v_o[h] = mem_resp_v_i & owner_v`, where h is the FIFO head. All other bits are 0.
- `mem_resp_yumi_o = mem_resp_yumi_i[h] & owner_v`. The FIFO pops on `mem_resp_yumi_o`.
- A response arriving while the FIFO is empty is never consumed, and a nonsynth assertion fires.
- Push and pop in the same cycle: count is unchanged and both take effect.

Reset:
- `reset_n_i=0` asynchronously forces `mem_cmd_v_o=0`, owner FIFO empty (count 0, pointers 0), and `rr_q=num_req_p-1`, so requester 0 has first priority.
- `mem_cmd_o` is cleared to 0.
- All combinational outputs (`mem_cmd_yumi_o`, `mem_resp_v_o`, `mem_resp_yumi_o`) are 0 while in reset.
- Reset mid-transaction discards in-flight ownership. The bench must also reset memory.

## Timing
- Command latency: `mem_cmd_v_i` high with grant at cycle t gives yumi at t and `mem_cmd_v_o` at t+1.
- Throughput: one command per cycle while `mem_cmd_ready_i=1` and the FIFO is not full.
- Response path is fully combinational: `mem_resp_v_i` → `mem_resp_v_o`, and `mem_resp_yumi_i` → `mem_resp_yumi_o`. Zero added latency.
- `mem_cmd_o` and `mem_cmd_v_o` are held stable while `mem_cmd_v_o & ~mem_cmd_ready_i`.
- Yumi outputs depend combinationally on `mem_cmd_v_i`, `mem_cmd_ready_i` and state. No path exists from `mem_resp_*` to `mem_cmd_yumi_o`.

## Structure
- No new shared typedefs. The message type is supplied by the `bp_me_pkg` macros at instantiation, and the block treats messages as opaque `msg_width_p` vectors.
- Sub-module `bp_me_rr_arbiter`: N-way round-robin with asynchronous active-low reset. Inputs: request vector and advance enable. Outputs: one-hot grant, encoded id, and the `rr_q` register.
- The owner FIFO is inline: circular buffer plus count, with async reset.

## Test plan
- Single requester: r0 issues 3 commands with `mem_cmd_ready_i=1`. Expect yumi at t, t+1, t+2; `mem_cmd_v_o` at t+1..t+3; the 3 responses all on `mem_resp_v_o=2'b01`.
- Fairness: both requesters continuously valid. Expect grant sequence 0,1,0,1. Responses route alternately to `2'b01` and `2'b10` in order.
- Backpressure: `mem_cmd_ready_i=0` for 5 cycles. Expect `mem_cmd_o` held constant, no yumi after the first load, and no FIFO push.
- FIFO full: 4 commands issued with responses withheld. Expect `owner_full`, yumi 0. Then one response with `mem_resp_yumi_i` the same cycle: no load that cycle, load the next cycle.
- Reset mid-operation: assert `reset_n_i=0` with 2 outstanding. Expect `mem_cmd_v_o=0` immediately. After release, r0 wins first.
- Consumer stall: the owner holds `mem_resp_yumi_i=0` for 3 cycles. Expect `mem_resp_yumi_o=0` and `mem_resp_v_o` steady; the FIFO pops only on the yumi.
